// File: rtl/s3_chien_forney.sv
// s3_chien_forney: Chien search plus Forney magnitude for RS(255,251), t=2, GF(2^8)/0x11D.
// Emits one registered err_pos/err_val beat per symbol, highest index first.
module s3_chien_forney (
  input  logic       clk,
  input  logic       rstn,
  input  logic       kes_done,
  input  logic [7:0] rs_lambda0,
  input  logic [7:0] rs_lambda1,
  input  logic [7:0] rs_lambda2,
  input  logic [7:0] rs_omega0,
  input  logic [7:0] rs_omega1,
  output logic       busy,
  output logic       err_vld,
  output logic [7:0] err_pos,
  output logic [7:0] err_val,
  output logic       chn_done,
  output logic [1:0] err_cnt,
  output logic       dec_fail
);
  typedef enum logic [3:0] {IDLE = 4'b0001, LOAD = 4'b0010, SCAN = 4'b0100, DONE = 4'b1000} state_t;
  state_t     state_q, state_d;
  logic [7:0] l0_q, l0_d, l1_q, l1_d, l2_q, l2_d, o0_q, o0_d, o1_q, o1_d;
  logic [7:0] t1_q, t1_d, t2_q, t2_d, xr_q, xr_d, inv_q, inv_d, c_q, c_d;
  logic [7:0] err_pos_q, err_pos_d, err_val_q, err_val_d;
  logic [1:0] cnt_q, cnt_d, err_cnt_q, err_cnt_d, deg;
  logic       err_vld_q, err_vld_d, dec_fail_q, dec_fail_d, live, root;
  function automatic logic [7:0] mul_a(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
  endfunction
  function automatic logic [7:0] mul_ainv(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'h8e : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      r = b[k] ? r ^ x : r;
      x = mul_a(x);
    end
    return r;
  endfunction
  // a^254 == a^-1 for nonzero a, and 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction
  always_comb begin
    state_d    = state_q;
    l0_d       = l0_q;
    l1_d       = l1_q;
    l2_d       = l2_q;
    o0_d       = o0_q;
    o1_d       = o1_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    xr_d       = xr_q;
    inv_d      = inv_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    dec_fail_d = dec_fail_q;
    deg        = l2_q != 8'h00 ? 2'd2 : l1_q != 8'h00 ? 2'd1 : 2'd0;
    // the extra SCAN cycle at c=255 only drains the output register
    live       = state_q == SCAN && c_q != 8'hff;
    root       = live && (l0_q ^ t1_q ^ t2_q) == 8'h00;
    err_vld_d  = live;
    err_pos_d  = live ? 8'd254 - c_q : 8'h00;
    err_val_d  = root ? gf_mul(gf_mul(o0_q, xr_q) ^ o1_q, inv_q) : 8'h00;
    state_d    = state_q == IDLE ? (kes_done ? LOAD : IDLE) :
                 state_q == LOAD ? SCAN :
                 state_q == SCAN ? (c_q == 8'hff ? DONE : SCAN) : IDLE;
    if (state_q == IDLE && kes_done) begin
      l0_d       = rs_lambda0;
      l1_d       = rs_lambda1;
      l2_d       = rs_lambda2;
      o0_d       = rs_omega0;
      o1_d       = rs_omega1;
      err_cnt_d  = 2'd0;
      dec_fail_d = 1'b0;
    end
    if (state_q == LOAD) begin
      t1_d  = mul_a(l1_q);
      t2_d  = mul_a(mul_a(l2_q));
      xr_d  = 8'h8e;
      c_d   = 8'h00;
      cnt_d = 2'd0;
      inv_d = gf_inv(l1_q);
    end
    if (state_q == SCAN) begin
      t1_d  = mul_a(t1_q);
      t2_d  = mul_a(mul_a(t2_q));
      xr_d  = mul_ainv(xr_q);
      c_d   = c_q + 8'd1;
      cnt_d = root && cnt_q != 2'd3 ? cnt_q + 2'd1 : cnt_q;
    end
    if (state_q == SCAN && c_q == 8'hff) begin
      err_cnt_d  = cnt_q;
      dec_fail_d = cnt_q != deg || (l2_q != 8'h00 && l1_q == 8'h00) || l0_q == 8'h00;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      l0_q       <= 8'h00;
      l1_q       <= 8'h00;
      l2_q       <= 8'h00;
      o0_q       <= 8'h00;
      o1_q       <= 8'h00;
      t1_q       <= 8'h00;
      t2_q       <= 8'h00;
      xr_q       <= 8'h00;
      inv_q      <= 8'h00;
      c_q        <= 8'h00;
      cnt_q      <= 2'd0;
      err_vld_q  <= 1'b0;
      err_pos_q  <= 8'h00;
      err_val_q  <= 8'h00;
      err_cnt_q  <= 2'd0;
      dec_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      l0_q       <= l0_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      o0_q       <= o0_d;
      o1_q       <= o1_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      xr_q       <= xr_d;
      inv_q      <= inv_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      err_vld_q  <= err_vld_d;
      err_pos_q  <= err_pos_d;
      err_val_q  <= err_val_d;
      err_cnt_q  <= err_cnt_d;
      dec_fail_q <= dec_fail_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign chn_done = state_q == DONE;
  assign err_vld  = err_vld_q;
  assign err_pos  = err_pos_q;
  assign err_val  = err_val_q;
  assign err_cnt  = err_cnt_q;
  assign dec_fail = dec_fail_q;
endmodule
